sync_fifo_flex: RTL

//   Single-clock FIFO with parametrised width, depth and read mode: standard

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 31 +++
 rtl/sync_fifo_flex.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: types shared by the single-clock FIFO and the async_fifo family.
//   fifo_mode_e selects the read-side behaviour:
//     FIFO_STD  - registered read, data valid one cycle after rd_en
//     FIFO_FWFT - first-word-fall-through, head word always visible
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x (1<<ADDR) dual-port storage, one synchronous write port
// and one asynchronous read port. The contents are not reset.
//   clk      in   1      write clock, rising edge
//   wr_en    in   1      write strobe
//   wr_addr  in   ADDR   write address
//   wr_data  in   WIDTH  write data
//   rd_addr  in   ADDR   read address
//   rd_data  out  WIDTH  combinational read data
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [ADDR-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with registered (STD) or
// first-word-fall-through (FWFT) read, occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and a
// synchronous flush.
//   clk           in   1       clock, rising edge
//   rst_n         in   1       asynchronous active-low reset
//   flush         in   1       synchronous clear of pointers/count/errors
//   w_data        in   WIDTH   write data
//   wr_en         in   1       write request
//   fifo_full     out  1       count == DEPTH
//   almost_full   out  1       count >= AF_LEVEL
//   rd_en         in   1       read request (STD) / pop head (FWFT)
//   r_data        out  WIDTH   read data
//   r_valid       out  1       STD: r_data valid; FWFT: !fifo_empty
//   fifo_empty    out  1       count == 0
//   almost_empty  out  1       count <= AE_LEVEL
//   count         out  ADDR+1  occupancy 0..DEPTH
//   overflow      out  1       sticky: wr_en while full
//   underflow     out  1       sticky: rd_en while empty
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter int         ADDR     = 4,
  parameter fifo_mode_e MODE     = FIFO_STD,
  parameter int         AF_LEVEL = (1 << ADDR) - 2,
  parameter int         AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] w_data,
  input  logic             wr_en,
  output logic             fifo_full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] r_data,
  output logic             r_valid,
  output logic             fifo_empty,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            DEPTH   = 1 << ADDR;
  localparam logic [ADDR:0] DEPTH_V = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AF_V    = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] AE_V    = (ADDR+1)'(AE_LEVEL);

  if (ADDR < 1) begin : g_chk_addr
    $error("sync_fifo_flex: ADDR must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $error("sync_fifo_flex: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_chk_ae
    $error("sync_fifo_flex: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic [ADDR:0]    count_next;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] mem_rd_data;

  assign fifo_full    = (count == DEPTH_V);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= AF_V);
  assign almost_empty = (count <= AE_V);

  assign wr_acc = wr_en & ~fifo_full;
  assign rd_acc = rd_en & ~fifo_empty;

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + (ADDR+1)'(1);
    else if (!wr_acc && rd_acc) count_next = count - (ADDR+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR'(1);
      count <= count_next;
      if (wr_en && fifo_full)  overflow  <= 1'b1;
      if (rd_en && fifo_empty) underflow <= 1'b1;
    end
  end

  // A write coinciding with flush is dropped, so the RAM is never written then.
  fifo_mem #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc & ~flush),
    .wr_addr (wr_ptr),
    .wr_data (w_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // The RAM is not reset, so the head is masked to zero while empty to give
    // a defined r_data out of reset.
    assign r_data  = fifo_empty ? '0 : mem_rd_data;
    assign r_valid = ~fifo_empty;
  end else begin : g_std
    logic [WIDTH-1:0] r_data_q;
    logic             r_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else if (flush) begin
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) r_data_q <= mem_rd_data;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule
